// File: rtl/dmem_responder.sv
// dmem_responder: data-memory responder for the MA-stage load/store requests.
// Single-port word RAM with fixed access latency, byte/half/word lane handling
// and error detection (illegal size, misalignment, out-of-range address).
// One request in flight at a time.
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   req_valid/req_ready request handshake (req_ready high only when idle)
//   req_addr            byte address
//   req_write           1 = store, 0 = load
//   req_wdata           right-aligned store data
//   req_size            00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned        loads: 1 = zero-extend, 0 = sign-extend
//   resp_valid/ready    response handshake
//   resp_rdata          extended load data (0 for stores and errors)
//   resp_error          request was rejected
//   busy                a request is in flight
module dmem_responder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        busy
);

  localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_write;
  logic [1:0]  lat_size;
  logic        lat_unsigned;

  logic [31:0] mem [DEPTH];

  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic        op_write;
  logic [1:0]  op_size;
  logic        op_unsigned;
  logic        accept;
  logic        access;
  logic        op_error;
  logic        mem_we;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [3:0]  lane_en;
  logic [31:0] wr_lanes;
  logic [31:0] wr_word;
  logic [31:0] rd_word;
  logic [31:0] rd_shift;
  logic [31:0] load_data;
  logic [31:0] access_rdata;

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);
  assign accept    = req_valid && req_ready;

  // With LATENCY 1 the access happens on the acceptance edge, before the
  // request is latched, so the live inputs are the operands while idle.
  always_comb begin
    op_addr     = lat_addr;
    op_wdata    = lat_wdata;
    op_write    = lat_write;
    op_size     = lat_size;
    op_unsigned = lat_unsigned;
    if (state == IDLE) begin
      op_addr     = req_addr;
      op_wdata    = req_wdata;
      op_write    = req_write;
      op_size     = req_size;
      op_unsigned = req_unsigned;
    end
  end

  assign access = (LATENCY == 1) ? accept : ((state == WAIT) && (cnt == 4'd1));

  assign op_error = (op_size == 2'b11)
                  || ((op_size == 2'b01) && op_addr[0])
                  || ((op_size == 2'b10) && (op_addr[1:0] != 2'b00))
                  || ((op_addr >> (ADDR_WIDTH + 2)) != 32'd0);

  assign word_idx = op_addr[ADDR_WIDTH+1:2];
  assign rd_word  = mem[word_idx];
  assign mem_we   = access && op_write && !op_error;

  // Lane enables and replicated store data; untouched lanes keep RAM contents.
  always_comb begin
    lane_en  = 4'b0000;
    wr_lanes = op_wdata;
    case (op_size)
      2'b00: begin
        lane_en  = 4'b0001 << op_addr[1:0];
        wr_lanes = {4{op_wdata[7:0]}};
      end
      2'b01: begin
        lane_en  = op_addr[1] ? 4'b1100 : 4'b0011;
        wr_lanes = {2{op_wdata[15:0]}};
      end
      2'b10:   lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
    for (int i = 0; i < 4; i++) begin
      wr_word[8*i +: 8] = lane_en[i] ? wr_lanes[8*i +: 8] : rd_word[8*i +: 8];
    end
  end

  // Load lane select and extension.
  always_comb begin
    rd_shift  = rd_word >> {op_addr[1:0], 3'b000};
    load_data = 32'd0;
    case (op_size)
      2'b00:   load_data = op_unsigned ? {24'd0, rd_shift[7:0]}
                                       : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01:   load_data = op_unsigned ? {16'd0, rd_shift[15:0]}
                                       : {{16{rd_shift[15]}}, rd_shift[15:0]};
      2'b10:   load_data = rd_word;
      default: load_data = 32'd0;
    endcase
  end

  assign access_rdata = (op_write || op_error) ? 32'd0 : load_data;

  // RAM array: not reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[word_idx] <= wr_word;
  end

  // Control FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= 4'd0;
      resp_valid   <= 1'b0;
      resp_rdata   <= 32'd0;
      resp_error   <= 1'b0;
      lat_addr     <= 32'd0;
      lat_wdata    <= 32'd0;
      lat_write    <= 1'b0;
      lat_size     <= 2'b00;
      lat_unsigned <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            lat_addr     <= req_addr;
            lat_wdata    <= req_wdata;
            lat_write    <= req_write;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            if (access) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= access_rdata;
              resp_error <= op_error;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (access) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= access_rdata;
            resp_error <= op_error;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_error <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Testbench for dmem_responder: four instances (LATENCY 1, 2, 4, 5) receive
// identical requests in lockstep. A byte-addressed reference memory per
// instance predicts each response; a monitor pops the expectations on every
// response handshake and checks latency, busy and req_ready each cycle.
`timescale 1ns/1ps
module tb_dmem_responder;

  localparam int unsigned NDUT = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        req_write;
  logic [31:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        resp_ready;
  logic        req_ready  [NDUT];
  logic        resp_valid [NDUT];
  logic [31:0] resp_rdata [NDUT];
  logic        resp_error [NDUT];
  logic        busy       [NDUT];

  function automatic int unsigned lat_of(int unsigned d);
    case (d)
      0:       return 1;
      1:       return 2;
      2:       return 4;
      default: return 5;
    endcase
  endfunction

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    dmem_responder #(.ADDR_WIDTH(10), .LATENCY(lat_of(g))) u_dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready[g]),
      .req_addr(req_addr), .req_write(req_write), .req_wdata(req_wdata),
      .req_size(req_size), .req_unsigned(req_unsigned),
      .resp_valid(resp_valid[g]), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata[g]), .resp_error(resp_error[g]), .busy(busy[g])
    );
  end

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          pend [NDUT];
  bit          prev [NDUT];
  int          acc  [NDUT];
  logic [32:0] exp_buf [NDUT][64];
  int          wp [NDUT];
  int          rp [NDUT];
  logic [7:0]  mem_m [NDUT][4096];
  bit          rand_bp = 1'b0;

  task automatic chk(string name, int d, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s dut%0d (lat %0d) got %h expected %h at %0t",
               name, d, lat_of(d), act, exp, $time);
    end
  endtask

  task automatic note_fail(string name, int d);
    checks++;
    errors++;
    $display("FAIL %s dut%0d (lat %0d) got unexpected event expected none at %0t",
             name, d, lat_of(d), $time);
  endtask

  // Reference behaviour: returns {error, rdata}; stores update the byte memory.
  function automatic logic [32:0] model_op(int d, logic [31:0] a, logic wr,
                                           logic [31:0] wd, logic [1:0] sz, logic un);
    logic [31:0] r;
    int nb;
    if (sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'd0) ||
        a >= 32'h1000)
      return {1'b1, 32'd0};
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    if (wr) begin
      for (int i = 0; i < nb; i++) mem_m[d][int'(a[11:0]) + i] = wd[8*i +: 8];
      return {1'b0, 32'd0};
    end
    r = 32'd0;
    for (int i = 0; i < nb; i++) r[8*i +: 8] = mem_m[d][int'(a[11:0]) + i];
    if (!un && nb < 4 && r[8*nb-1])
      for (int i = nb; i < 4; i++) r[8*i +: 8] = 8'hFF;
    return {1'b0, r};
  endfunction

  // Push the expected response for every instance whose latency is <= max_lat.
  task automatic push_all(logic [31:0] a, logic wr, logic [31:0] wd,
                          logic [1:0] sz, logic un, int unsigned max_lat);
    for (int d = 0; d < NDUT; d++) begin
      if (lat_of(d) <= max_lat) begin
        exp_buf[d][wp[d] % 64] = model_op(d, a, wr, wd, sz, un);
        wp[d]++;
      end
    end
  endtask

  task automatic drive(logic [31:0] a, logic wr, logic [31:0] wd, logic [1:0] sz, logic un);
    req_addr = a; req_write = wr; req_wdata = wd; req_size = sz; req_unsigned = un;
    req_valid = 1'b1;
  endtask

  task automatic scramble();
    req_addr = $urandom; req_write = 1'($urandom); req_wdata = $urandom;
    req_size = 2'($urandom); req_unsigned = 1'($urandom);
  endtask

  function automatic bit all_idle();
    for (int d = 0; d < NDUT; d++) if (req_ready[d] !== 1'b1) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while (!all_idle()) begin
      if (n >= 200) begin
        note_fail("idle_timeout", 0);
        break;
      end
      @(posedge clk); #1;
      if (rand_bp) resp_ready = 1'($urandom);
      n++;
    end
    resp_ready = 1'b1;
  endtask

  task automatic issue(logic [31:0] a, logic wr, logic [31:0] wd, logic [1:0] sz, logic un);
    push_all(a, wr, wd, sz, un, 15);
    drive(a, wr, wd, sz, un);
    @(posedge clk); #1;
    req_valid = 1'b0;
    scramble();
    wait_idle();
  endtask

  // Per-cycle monitor: decisions use values sampled before the next rising edge.
  task automatic mon_step();
    logic [32:0] e;
    cyc++;
    for (int d = 0; d < NDUT; d++) begin
      if (rst !== 1'b1) begin
        pend[d] = 1'b0;
        prev[d] = 1'b0;
        continue;
      end
      chk("busy", d, 32'(busy[d]), 32'(pend[d]));
      chk("req_ready", d, 32'(req_ready[d]), 32'(!pend[d]));
      if (resp_valid[d] === 1'b1 && !prev[d]) begin
        if (!pend[d]) note_fail("resp_valid_idle", d);
        else chk("latency", d, 32'(cyc - acc[d]), 32'(lat_of(d)));
      end
      if (resp_valid[d] === 1'b1 && resp_ready) begin
        if (rp[d] == wp[d]) note_fail("resp_unexpected", d);
        else begin
          e = exp_buf[d][rp[d] % 64];
          rp[d]++;
          chk("rdata", d, resp_rdata[d], e[31:0]);
          chk("error", d, 32'(resp_error[d]), 32'(e[32]));
        end
        pend[d] = 1'b0;
      end else if (!pend[d] && req_valid) begin
        pend[d] = 1'b1;
        acc[d]  = cyc;
      end
      prev[d] = (resp_valid[d] === 1'b1);
    end
  endtask

  task automatic run_stim();
    logic [31:0] exp_a [NDUT];
    logic [31:0] a;
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
    req_size = 2'b00; req_unsigned = 1'b0; resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk("rst_req_ready", d, 32'(req_ready[d]), 32'd1);
      chk("rst_resp_valid", d, 32'(resp_valid[d]), 32'd0);
      chk("rst_rdata", d, resp_rdata[d], 32'd0);
      chk("rst_error", d, 32'(resp_error[d]), 32'd0);
      chk("rst_busy", d, 32'(busy[d]), 32'd0);
    end
    rst = 1'b1;
    @(posedge clk); #1;

    // Word store/load, byte and half lanes.
    issue(32'h10, 1'b1, 32'hDEADBEEF, 2'd2, 1'b0);
    issue(32'h10, 1'b0, 32'h0, 2'd2, 1'b0);
    issue(32'h11, 1'b1, 32'h12345680, 2'd0, 1'b0);
    issue(32'h10, 1'b0, 32'h0, 2'd2, 1'b0);
    issue(32'h11, 1'b0, 32'h0, 2'd0, 1'b0);
    issue(32'h11, 1'b0, 32'h0, 2'd0, 1'b1);
    issue(32'h12, 1'b0, 32'h0, 2'd1, 1'b0);
    issue(32'h12, 1'b0, 32'h0, 2'd1, 1'b1);

    // Error cases; erroneous stores must leave memory untouched.
    issue(32'h13, 1'b0, 32'h0, 2'd1, 1'b0);
    issue(32'h1002, 1'b1, 32'h55555555, 2'd2, 1'b0);
    issue(32'h12, 1'b1, 32'h55555555, 2'd2, 1'b0);
    issue(32'h13, 1'b1, 32'h5555, 2'd1, 1'b0);
    issue(32'h10, 1'b1, 32'h55555555, 2'd3, 1'b0);
    issue(32'h10, 1'b0, 32'h0, 2'd3, 1'b0);
    issue(32'h1000, 1'b0, 32'h0, 2'd2, 1'b0);
    issue(32'h80000010, 1'b1, 32'h55555555, 2'd2, 1'b0);
    issue(32'h10, 1'b0, 32'h0, 2'd2, 1'b0);

    // Backpressure: response held, second request ignored until handshake.
    resp_ready = 1'b0;
    push_all(32'h10, 1'b0, 32'h0, 2'd2, 1'b0, 15);
    for (int d = 0; d < NDUT; d++) exp_a[d] = exp_buf[d][(wp[d] - 1) % 64][31:0];
    drive(32'h10, 1'b0, 32'h0, 2'd2, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    scramble();
    repeat (6) @(posedge clk);
    #1;
    push_all(32'h11, 1'b0, 32'h0, 2'd0, 1'b1, 15);
    drive(32'h11, 1'b0, 32'h0, 2'd0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      for (int d = 0; d < NDUT; d++) begin
        chk("bp_resp_valid", d, 32'(resp_valid[d]), 32'd1);
        chk("bp_rdata", d, resp_rdata[d], exp_a[d]);
        chk("bp_req_ready", d, 32'(req_ready[d]), 32'd0);
      end
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    for (int d = 0; d < NDUT; d++) begin
      chk("hs_req_ready", d, 32'(req_ready[d]), 32'd1);
      chk("hs_resp_valid", d, 32'(resp_valid[d]), 32'd0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    scramble();
    for (int d = 0; d < NDUT; d++) chk("second_accept_busy", d, 32'(busy[d]), 32'd1);
    wait_idle();

    // Reset two cycles after acceptance: only instances whose access edge
    // precedes the reset (latency <= 2) commit the store and respond.
    issue(32'h20, 1'b1, 32'hAAAAAAAA, 2'd2, 1'b0);
    push_all(32'h20, 1'b1, 32'h12345678, 2'd2, 1'b0, 2);
    drive(32'h20, 1'b1, 32'h12345678, 2'd2, 1'b0);
    @(posedge clk); #1;
    req_valid = 1'b0;
    scramble();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    for (int d = 0; d < NDUT; d++) begin
      chk("abort_resp_valid", d, 32'(resp_valid[d]), 32'd0);
      chk("abort_busy", d, 32'(busy[d]), 32'd0);
      chk("abort_req_ready", d, 32'(req_ready[d]), 32'd1);
      chk("abort_rdata", d, resp_rdata[d], 32'd0);
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    issue(32'h20, 1'b0, 32'h0, 2'd2, 1'b0);

    // Randomized traffic over an initialised region with random backpressure.
    for (int i = 0; i < 64; i++) issue(32'(i * 4), 1'b1, $urandom, 2'd2, 1'b0);
    rand_bp = 1'b1;
    for (int i = 0; i < 150; i++) begin
      a = 32'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) a = a | (32'h1000 << $urandom_range(0, 19));
      issue(a, 1'($urandom_range(0, 1)), $urandom, 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)));
    end
    rand_bp = 1'b0;
    resp_ready = 1'b1;
    wait_idle();
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NDUT; d++) chk("drained", d, 32'(rp[d]), 32'(wp[d]));
  endtask

  initial begin
    for (int d = 0; d < NDUT; d++) begin
      pend[d] = 1'b0; prev[d] = 1'b0; acc[d] = 0; wp[d] = 0; rp[d] = 0;
    end
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
      run_stim();
      begin
        #600000;
        note_fail("global_timeout", 0);
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
